// File: rtl/game_flow_if.sv
// game_flow_if: inputs and status outputs of the game sequencer.
// The bench drives through master; the controller uses slave.
interface game_flow_if;
    logic       vsync;
    logic       btn_start;
    logic       btn_pause;
    logic       collision;
    logic       level_clear;
    logic       frame_pulse;
    logic       frame_tick;
    logic       game_reset;
    logic [1:0] lives;
    logic [2:0] state;
    logic       game_over;

    modport master (
        output vsync, btn_start, btn_pause, collision, level_clear,
        input  frame_pulse, frame_tick, game_reset, lives, state, game_over
    );

    modport slave (
        input  vsync, btn_start, btn_pause, collision, level_clear,
        output frame_pulse, frame_tick, game_reset, lives, state, game_over
    );
endinterface

// File: rtl/game_flow_ctrl.sv
// game_flow_ctrl: IDLE/READY/PLAY/PAUSE/HIT/OVER/WIN sequencer.
// Converts VSYNC into frame pulses and gates the movers' frame_tick.
module game_flow_ctrl #(
    parameter int LIVES_INIT   = 3,
    parameter int READY_FRAMES = 120,
    parameter int HIT_FRAMES   = 90,
    parameter int OVER_FRAMES  = 300
) (
    input logic         clk_pix,
    input logic         rstn,
    game_flow_if.slave  gf
);
    typedef enum logic [2:0] {IDLE, READY, PLAY, PAUSE, HIT, OVER, WIN} state_t;

    localparam logic [8:0] C_READY = 9'(READY_FRAMES - 1);
    localparam logic [8:0] C_HIT   = 9'(HIT_FRAMES - 1);
    localparam logic [8:0] C_OVER  = 9'(OVER_FRAMES - 1);
    localparam logic [1:0] C_LIVES = 2'(LIVES_INIT);

    state_t     r_state, w_state_n;
    logic [8:0] r_cnt, w_cnt_n;
    logic [1:0] r_lives, w_lives_n;
    logic       r_vs_d, r_start_d, r_pause_d;
    logic       r_fp, r_tick, r_start_rise, r_pause_rise;
    logic       r_gr_pulse, w_gr_pulse_n;
    logic       w_expire;

    assign w_expire = r_fp && (r_cnt == 9'd0);

    always_ff @(posedge clk_pix or negedge rstn) begin
        if (!rstn) begin
            r_vs_d       <= 1'b0;
            r_start_d    <= 1'b0;
            r_pause_d    <= 1'b0;
            r_fp         <= 1'b0;
            r_tick       <= 1'b0;
            r_start_rise <= 1'b0;
            r_pause_rise <= 1'b0;
            r_gr_pulse   <= 1'b0;
            r_state      <= IDLE;
            r_cnt        <= 9'd0;
            r_lives      <= C_LIVES;
        end else begin
            r_vs_d       <= gf.vsync;
            r_start_d    <= gf.btn_start;
            r_pause_d    <= gf.btn_pause;
            r_fp         <= gf.vsync & ~r_vs_d;
            r_tick       <= gf.vsync & ~r_vs_d & (r_state == PLAY);
            r_start_rise <= gf.btn_start & ~r_start_d;
            r_pause_rise <= gf.btn_pause & ~r_pause_d;
            r_gr_pulse   <= w_gr_pulse_n;
            r_state      <= w_state_n;
            r_cnt        <= w_cnt_n;
            r_lives      <= w_lives_n;
        end
    end

    // Every timed state overrides the free-running decrement with its own load on entry.
    always_comb begin
        w_state_n    = r_state;
        w_cnt_n      = (r_fp && r_cnt != 9'd0) ? r_cnt - 9'd1 : r_cnt;
        w_lives_n    = r_lives;
        w_gr_pulse_n = 1'b0;
        case (r_state)
            IDLE: if (r_start_rise) begin
                w_state_n = READY;
                w_cnt_n   = C_READY;
            end
            READY: if (w_expire) w_state_n = PLAY;
            PLAY: if (gf.collision) begin
                w_state_n = HIT;
                w_cnt_n   = C_HIT;
                w_lives_n = (r_lives == 2'd0) ? 2'd0 : r_lives - 2'd1;
            end else if (gf.level_clear) begin
                w_state_n = WIN;
            end else if (r_pause_rise) begin
                w_state_n = PAUSE;
            end
            PAUSE: if (r_pause_rise) w_state_n = PLAY;
            HIT: if (w_expire) begin
                w_state_n    = (r_lives == 2'd0) ? OVER : READY;
                w_cnt_n      = (r_lives == 2'd0) ? C_OVER : C_READY;
                w_gr_pulse_n = (r_lives != 2'd0);
            end
            OVER: if (r_start_rise || w_expire) begin
                w_state_n = IDLE;
                w_lives_n = C_LIVES;
            end
            WIN: if (r_start_rise) begin
                w_state_n    = READY;
                w_cnt_n      = C_READY;
                w_gr_pulse_n = 1'b1;
            end
            default: w_state_n = IDLE;
        endcase
    end

    assign gf.frame_pulse = r_fp;
    assign gf.frame_tick  = r_tick;
    assign gf.game_reset  = (r_state == IDLE) | r_gr_pulse;
    assign gf.lives       = r_lives;
    assign gf.state       = r_state;
    assign gf.game_over   = (r_state == OVER);
endmodule

// File: tb/tb_game_flow_ctrl.sv
// tb_game_flow_ctrl: directed game scenarios plus random stimulus, with every
// cycle's outputs predicted by a frame-counting game model and checked from a queue.
module tb_game_flow_ctrl;
    localparam int LI = 3, RF = 120, HF = 90, OF = 300;

    typedef struct packed {
        logic       fp;
        logic       tick;
        logic       gr;
        logic       go;
        logic [1:0] lives;
        logic [2:0] st;
    } exp_t;

    logic clk_pix = 1'b0;
    logic rstn    = 1'b0;
    always #5 clk_pix = ~clk_pix;

    game_flow_if gf();
    game_flow_ctrl #(.LIVES_INIT(LI), .READY_FRAMES(RF), .HIT_FRAMES(HF), .OVER_FRAMES(OF))
        dut (.clk_pix(clk_pix), .rstn(rstn), .gf(gf));

    exp_t q[$];
    int   errors = 0, checks = 0;

    bit v_rst = 0, v_vs = 0, v_s = 0, v_p = 0, v_c = 0, v_l = 0;

    // Game model: mode is the play phase, left is frames still to be shown in it.
    int m_mode, m_left, m_lives;
    bit m_vs, m_sd, m_pd, m_fp, m_tick, m_st, m_pa, m_grp;

    function automatic void m_reset();
        m_mode = 0; m_left = 0; m_lives = LI;
        {m_vs, m_sd, m_pd, m_fp, m_tick, m_st, m_pa, m_grp} = '0;
    endfunction

    function automatic void enter(int mode, int frames);
        m_mode = mode;
        m_left = frames;
    endfunction

    function automatic void m_step();
        bit fp = m_fp, st = m_st, pa = m_pa;
        m_grp  = 0;
        m_tick = v_vs && !m_vs && m_mode == 2;
        m_fp   = v_vs && !m_vs;
        m_st   = v_s && !m_sd;
        m_pa   = v_p && !m_pd;
        m_vs = v_vs; m_sd = v_s; m_pd = v_p;
        if (fp && (m_mode == 1 || m_mode == 4 || m_mode == 5)) m_left--;
        case (m_mode)
            0: if (st) enter(1, RF);
            1: if (m_left == 0) m_mode = 2;
            2: if (v_c) begin
                   m_lives = (m_lives > 0) ? m_lives - 1 : 0;
                   enter(4, HF);
               end else if (v_l) m_mode = 6;
               else if (pa) m_mode = 3;
            3: if (pa) m_mode = 2;
            4: if (m_left == 0) begin
                   if (m_lives == 0) enter(5, OF);
                   else begin enter(1, RF); m_grp = 1; end
               end
            5: if (st || m_left == 0) begin m_mode = 0; m_lives = LI; end
            6: if (st) begin enter(1, RF); m_grp = 1; end
            default: m_mode = 0;
        endcase
    endfunction

    function automatic exp_t m_out();
        exp_t e;
        e.fp = m_fp; e.tick = m_tick; e.gr = (m_mode == 0) || m_grp;
        e.go = (m_mode == 5); e.lives = 2'(m_lives); e.st = 3'(m_mode);
        return e;
    endfunction

    function automatic exp_t dut_out();
        exp_t a;
        a.fp = gf.frame_pulse; a.tick = gf.frame_tick; a.gr = gf.game_reset;
        a.go = gf.game_over; a.lives = gf.lives; a.st = gf.state;
        return a;
    endfunction

    function automatic void chk(string nm, exp_t a, exp_t e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s @%0t: got fp=%0b tick=%0b gr=%0b go=%0b lives=%0d st=%0d, want fp=%0b tick=%0b gr=%0b go=%0b lives=%0d st=%0d",
                     nm, $time, a.fp, a.tick, a.gr, a.go, a.lives, a.st,
                     e.fp, e.tick, e.gr, e.go, e.lives, e.st);
        end
    endfunction

    task automatic cyc();
        @(negedge clk_pix);
        rstn = v_rst;
        gf.vsync = v_vs; gf.btn_start = v_s; gf.btn_pause = v_p;
        gf.collision = v_c; gf.level_clear = v_l;
        if (!v_rst) m_reset(); else m_step();
        q.push_back(m_out());
    endtask

    task automatic tick(int n);
        repeat (n) cyc();
    endtask

    task automatic frames(int n);
        repeat (n) begin
            v_vs = 1; tick(2);
            v_vs = 0; tick(2);
        end
    endtask

    task automatic press_start();
        v_s = 1; tick(2); v_s = 0; tick(1);
    endtask

    task automatic press_pause();
        v_p = 1; tick(2); v_p = 0; tick(1);
    endtask

    task automatic hit();
        v_c = 1; tick(1); v_c = 0; frames(HF + 1);
    endtask

    task automatic rst_async();
        @(negedge clk_pix);
        #2 rstn = 0;
        v_rst = 0;
        m_reset();
        #1 chk("async_reset", dut_out(), m_out());
        q.push_back(m_out());
    endtask

    initial begin
        forever begin
            @(posedge clk_pix);
            #1;
            if (q.size() > 0) chk("cycle", dut_out(), q.pop_front());
        end
    end

    initial begin
        int vs_left = 0;
        tick(3);
        v_rst = 1; tick(2);
        press_start();
        frames(RF + 2);
        v_vs = 1; tick(100); v_vs = 0; tick(3);
        frames(2);
        press_pause();
        frames(2);
        v_c = 1; tick(2); v_c = 0;
        press_pause();
        frames(2);
        v_c = 1; v_l = 1; tick(1); v_c = 0; v_l = 0;
        frames(HF + 1);
        press_pause();
        frames(RF + 1);
        hit(); frames(RF + 1);
        hit(); frames(OF + 2);
        press_start(); frames(RF + 1);
        hit(); frames(RF + 1);
        hit(); frames(RF + 1);
        hit(); frames(10);
        press_start();
        press_start(); frames(RF + 1);
        v_l = 1; tick(1); v_l = 0; frames(3);
        press_start(); frames(RF + 1);
        v_c = 1; tick(1); v_c = 0; frames(40);
        rst_async(); tick(2);
        v_rst = 1; tick(3);
        for (int k = 0; k < 20000; k++) begin
            if (vs_left == 0) begin
                v_vs = ~v_vs;
                vs_left = ($urandom_range(0, 30) == 0) ? 100 : $urandom_range(1, 10);
            end
            vs_left--;
            if ($urandom_range(0, 39) == 0) v_s = ~v_s;
            if ($urandom_range(0, 59) == 0) v_p = ~v_p;
            v_c = ($urandom_range(0, 299) == 0) ? 1'b1 : (v_c && $urandom_range(0, 2) != 0);
            v_l = ($urandom_range(0, 2999) == 0);
            if ($urandom_range(0, 6999) == 0) begin
                rst_async(); tick(2); v_rst = 1;
            end
            cyc();
        end
        tick(2);
        repeat (3) @(posedge clk_pix);
        #2;
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expected entries left, want 0", q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
